// File: rtl/mux_n_reg.sv
// Registered N-input operand select with valid, stall/flush and a sticky
// flag for out-of-range selects; sits on a pipeline stage boundary.
module mux_n_reg #(
  parameter int WIDTH  = 32,
  parameter int INPUTS = 4,
  parameter int SEL_W  = $clog2(INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [SEL_W-1:0]        sel,
  input  logic [INPUTS*WIDTH-1:0] in_bus,
  input  logic                    err_clr,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;
  logic             load;
  logic             load_bad;

  // A miss (no matching index) is exactly the out-of-range case; this also
  // keeps the decode free of constant compares when INPUTS is a power of two.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (SEL_W'(i) == sel) begin
        sel_data = in_bus[i*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  assign load     = !flush && !stall;
  assign load_bad = load && in_valid && !sel_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      sel_err   <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_sel   <= '0;
      end else if (load) begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_sel  <= sel;
          out_data <= sel_data;
        end
      end
      // set beats clear when both land on the same edge
      if (load_bad) begin
        sel_err <= 1'b1;
      end else if (err_clr) begin
        sel_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_reg.sv
// Bench for mux_n_reg: a 4-input and a 5-input instance share stimulus; a
// reference model pushes expected outputs per edge and they are popped after it.
module tb_mux_n_reg;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [2:0]  s;
    logic        e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, stall, flush, err_clr;
  logic [2:0]   sel;
  logic [159:0] in_bus;

  logic         v4, v5, e4, e5;
  logic [31:0]  d4, d5;
  logic [1:0]   s4;
  logic [2:0]   s5;

  exp_t m4, m5;
  exp_t q4[$];
  exp_t q5[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mux_n_reg #(.WIDTH(32), .INPUTS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .sel(sel[1:0]), .in_bus(in_bus[127:0]), .err_clr(err_clr),
    .out_valid(v4), .out_data(d4), .out_sel(s4), .sel_err(e4)
  );

  mux_n_reg #(.WIDTH(32), .INPUTS(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .sel(sel), .in_bus(in_bus), .err_clr(err_clr),
    .out_valid(v5), .out_data(d5), .out_sel(s5), .sel_err(e5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic exp_t model(input exp_t m, input int n);
    exp_t       r;
    logic [2:0] se;
    int         idx;
    logic       bad;
    r   = m;
    se  = (n == 4) ? (sel & 3'd3) : sel;
    idx = int'(se);
    bad = 1'b0;
    if (flush) begin
      r.v = 1'b0; r.d = '0; r.s = '0;
    end else if (!stall) begin
      r.v = in_valid;
      if (in_valid) begin
        r.s = se;
        if (idx < n) r.d = in_bus[idx*32 +: 32];
        else begin r.d = '0; bad = 1'b1; end
      end
    end
    if (bad) r.e = 1'b1;
    else if (err_clr) r.e = 1'b0;
    return r;
  endfunction

  task automatic cycle(input string tag);
    exp_t x4, x5;
    m4 = model(m4, 4);
    m5 = model(m5, 5);
    q4.push_back(m4);
    q5.push_back(m5);
    @(posedge clk);
    #1;
    x4 = q4.pop_front();
    x5 = q5.pop_front();
    chk({tag, "/v4"}, {31'd0, v4}, {31'd0, x4.v});
    chk({tag, "/d4"}, d4, x4.d);
    chk({tag, "/s4"}, {30'd0, s4}, {29'd0, x4.s});
    chk({tag, "/e4"}, {31'd0, e4}, {31'd0, x4.e});
    chk({tag, "/v5"}, {31'd0, v5}, {31'd0, x5.v});
    chk({tag, "/d5"}, d5, x5.d);
    chk({tag, "/s5"}, {29'd0, s5}, {29'd0, x5.s});
    chk({tag, "/e5"}, {31'd0, e5}, {31'd0, x5.e});
  endtask

  task automatic drive(input logic iv, input logic [2:0] s, input logic st,
                       input logic fl, input logic ec);
    in_valid = iv; sel = s; stall = st; flush = fl; err_clr = ec;
  endtask

  task automatic canon_bus();
    for (int i = 0; i < 5; i++) in_bus[i*32 +: 32] = 32'h11111111 * (i + 1);
  endtask

  task automatic zero_model();
    m4 = '{1'b0, 32'd0, 3'd0, 1'b0};
    m5 = '{1'b0, 32'd0, 3'd0, 1'b0};
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    canon_bus();
    zero_model();
    #12;
    chk("rst/v4", {31'd0, v4}, 32'd0);
    chk("rst/d5", d5, 32'd0);
    chk("rst/e5", {31'd0, e5}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    cycle("load2");
    chk("load2/const_d4", d4, 32'h33333333);
    chk("load2/const_s4", {30'd0, s4}, 32'd2);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
      cycle($sformatf("sweep%0d", i));
      chk($sformatf("sweep%0d/const", i), d4, 32'h11111111 * (i + 1));
    end

    drive(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    cycle("oor7");
    chk("oor7/const_d5", d5, 32'd0);
    chk("oor7/const_e5", {31'd0, e5}, 32'd1);
    chk("oor7/const_s5", {29'd0, s5}, 32'd7);
    drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    cycle("sticky");
    drive(1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
    cycle("set_beats_clr");
    chk("set_beats_clr/const", {31'd0, e5}, 32'd1);
    drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    cycle("clr");
    chk("clr/const", {31'd0, e5}, 32'd0);

    drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    cycle("pre_stall");
    for (int i = 0; i < 3; i++) begin
      in_bus = {5{$urandom()}};
      drive(1'(i), 3'(i + 2), 1'b1, 1'b0, 1'b0);
      cycle($sformatf("stall%0d", i));
      chk($sformatf("stall%0d/const", i), d4, 32'h22222222);
    end
    canon_bus();
    drive(1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
    cycle("stall_flush");
    chk("stall_flush/const_v", {31'd0, v5}, 32'd0);
    chk("stall_flush/const_d", d5, 32'd0);

    drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    cycle("pre_bubble");
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle("bubble");
    chk("bubble/const_d4", d4, 32'h44444444);

    drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    cycle("oor5");
    drive(1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
    cycle("clr_in_stall");
    drive(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    cycle("oor6");
    drive(1'b1, 3'd0, 1'b0, 1'b1, 1'b1);
    cycle("clr_in_flush");
    drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    cycle("last_input");

    drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    cycle("pre_areset");
    #2;
    rst_n = 1'b0;
    #1;
    zero_model();
    chk("areset/v4", {31'd0, v4}, 32'd0);
    chk("areset/d4", d4, 32'd0);
    chk("areset/s5", {29'd0, s5}, 32'd0);
    chk("areset/v5", {31'd0, v5}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle("post_areset");
    chk("post_areset/const", d4, 32'h11111111);

    for (int i = 0; i < 20; i++) begin
      in_bus = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 3) == 0));
      cycle($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux_n_reg.md
# mux_n_reg

Parametrised N-input, W-bit registered operand multiplexer with a valid flag, stall and flush, and an error flag for out-of-range selects. It generalises the datapath 2:1 selects to any input count and width. It also adds one pipeline register, so it can sit on a stage boundary, for example forwarding-source or write-back-source selection, and obey the pipeline's stall and flush controls.

## Interface
Parameters:
- WIDTH, 32, data width of each input and of the output
- INPUTS, 4, number of data inputs; legal range 2..16; need not be a power of two
- SEL_W, $clog2(INPUTS), select width; derived, never overridden

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  current inputs and select are meaningful this cycle
- stall  input  1  hold all registered state
- flush  input  1  kill the registered entry
- sel  input  SEL_W  binary index of the input to forward
- in_bus  input  INPUTS*WIDTH  flattened inputs; input i = in_bus[i*WIDTH +: WIDTH]
- err_clr  input  1  clear sel_err
- out_valid  output  1  out_data holds a live entry
- out_data  output  WIDTH  registered selected input
- out_sel  output  SEL_W  registered copy of the sel that produced out_data
- sel_err  output  1  sticky: an out-of-range sel was loaded with in_valid=1

## Operation
- All outputs are registered. No combinational path from any input to any output.
- Per-edge update priority is flush > stall > load.
- Flush:
  - out_valid <= 0, out_data <= 0, out_sel <= 0.
  - sel_err is unaffected, except that err_clr still applies.
- Stall (with no flush): out_valid, out_data and out_sel hold.
- Load (no flush, no stall):
  - out_valid <= in_valid.
  - If in_valid=1: out_sel <= sel. out_data <= input[sel] when sel < INPUTS; otherwise out_data <= 0 and sel_err is set.
  - If in_valid=0: out_data and out_sel hold their previous values; only out_valid drops.
- sel_err:
  - Set only on a load edge with in_valid=1 and sel >= INPUTS.
  - Cleared by err_clr=1 on any edge, including during stall or flush.
  - If set and clear occur on the same edge, set wins.
- An out-of-range select still produces a valid entry (out_valid=1, data 0), so pipeline occupancy stays consistent.
- Width rules:
  - sel is compared unsigned against INPUTS.
  - out_data is an exact copy of the selected input; there is no sign or zero extension.

## Timing
- Latency: 1 cycle. Inputs sampled at edge k appear on the outputs after edge k.
- Throughput: one entry per cycle when stall=0.
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_sel=0, sel_err=0, immediately and independent of clk.
  - Release is synchronous to the next clk edge.
  - Reset mid-stall or mid-flush discards all state. After release, the first load edge behaves normally.
- stall=1 for M cycles freezes the outputs for exactly M edges. The edge after stall falls performs a normal load.
- flush and stall asserted together: flush wins, so the output is empty after that edge.
- in_valid changes while stalled are ignored. The value sampled is the one present on the first non-stalled edge.

## Test plan
- Reset then load: INPUTS=4, WIDTH=32, in_bus inputs 0..3 = 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, in_valid=1 -> after one edge out_valid=1, out_data=0x33333333, out_sel=2, sel_err=0.
- Sweep: sel=0,1,2,3 on consecutive cycles -> out_data follows one cycle later in the same order, with no bubbles.
- Out-of-range: INPUTS=5, sel=7, in_valid=1 -> out_valid=1, out_data=0, out_sel=7, sel_err=1. sel_err stays 1 through later legal loads until err_clr=1; with err_clr=1 and a bad sel on the same edge, sel_err stays 1.
- Stall and flush:
  - Load 0x22222222, then stall=1 for 3 cycles with inputs changing -> outputs frozen at 0x22222222/valid=1.
  - Then stall=1 and flush=1 together -> out_valid=0, out_data=0.
- Bubble: in_valid=0 after a valid load of 0x44444444 -> out_valid=0, out_data holds 0x44444444.
- Async reset: assert rst_n=0 between edges while out_valid=1 -> all outputs read 0 before the next edge. Deassert -> the next load operates normally.
